// File: rtl/uart_tx.sv
// uart_tx: UART serializer with start bit, LSB-first payload, optional parity
// and one or two stop bits; registered line output, one frame at a time.
module uart_tx #(
    parameter int UART_DATA_WIDTH = 8,
    parameter int CLKS_PER_BIT    = 434,
    parameter int PARITY_EN       = 0,
    parameter int PARITY_ODD      = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       uart_dv,
    input  logic [UART_DATA_WIDTH-1:0] uart_data,
    output logic                       uart_tx_done,
    output logic                       tx_busy,
    output logic                       tx_serial
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(UART_DATA_WIDTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(UART_DATA_WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]                 state;
    logic [BW-1:0]              baud;
    logic [CW-1:0]              bit_cnt;
    logic [UART_DATA_WIDTH-1:0] shreg;
    logic                       par;
    logic                       wrap;

    assign wrap = baud == BAUD_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            baud         <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par          <= 1'b0;
            tx_serial    <= 1'b1;
            tx_busy      <= 1'b0;
            uart_tx_done <= 1'b0;
        end else begin
            uart_tx_done <= 1'b0;
            // baud counter only runs while a frame is on the line
            baud <= (tx_busy && !wrap) ? baud + 1'b1 : '0;
            case (state)
                IDLE: if (uart_dv) begin
                    shreg     <= uart_data;
                    par       <= (^uart_data) ^ (PARITY_ODD != 0);
                    bit_cnt   <= '0;
                    state     <= START;
                    tx_serial <= 1'b0;
                    tx_busy   <= 1'b1;
                end
                START: if (wrap) begin
                    state     <= DATA;
                    tx_serial <= shreg[0];
                    shreg     <= shreg >> 1;
                end
                DATA: if (wrap) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt   <= '0;
                        state     <= (PARITY_EN != 0) ? PARITY : STOP;
                        tx_serial <= (PARITY_EN != 0) ? par : 1'b1;
                    end else begin
                        bit_cnt   <= bit_cnt + 1'b1;
                        tx_serial <= shreg[0];
                        shreg     <= shreg >> 1;
                    end
                end
                PARITY: if (wrap) begin
                    state     <= STOP;
                    tx_serial <= 1'b1;
                end
                STOP: if (wrap) begin
                    if (bit_cnt == STOP_LAST) begin
                        state        <= DONE;
                        uart_tx_done <= 1'b1;
                        tx_busy      <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: cycle-exact frame checks on four configurations (8N1, 8E1, 8O1, 8N2)
// sharing one clock and reset; decoded payloads are matched against a byte scoreboard.
module tb_uart_tx;
    localparam int CPB = 4;

    typedef struct {
        logic [1:0] u;
        logic [7:0] d;
        int         g1;
        int         g2;
        int         len;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dv = '0;
    logic [7:0] data [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [3:0] done, busy, ser;
    logic [7:0] sb_q [$];
    logic [7:0] fifo [$];
    int         passed = 0;
    int         total = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB)) u0 (
        .clk(clk), .rst_n(rst_n), .uart_dv(dv[0]), .uart_data(data[0]),
        .uart_tx_done(done[0]), .tx_busy(busy[0]), .tx_serial(ser[0]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .uart_dv(dv[1]), .uart_data(data[1]),
        .uart_tx_done(done[1]), .tx_busy(busy[1]), .tx_serial(ser[1]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst_n(rst_n), .uart_dv(dv[2]), .uart_data(data[2]),
        .uart_tx_done(done[2]), .tx_busy(busy[2]), .tx_serial(ser[2]));
    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .uart_dv(dv[3]), .uart_data(data[3]),
        .uart_tx_done(done[3]), .tx_busy(busy[3]), .tx_serial(ser[3]));

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s got %h want %h", name, act, exp);
    endtask

    task automatic idle_check(input logic [1:0] u, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("idle u%0d", u), {5'd0, ser[u], busy[u], done[u]}, 8'b100);
        end
    endtask

    // Drives one frame from a negedge and checks {serial,busy,done} every cycle up to DONE+1.
    task automatic run_frame(input vec_t v);
        logic [11:0] fr;
        logic [7:0]  got;
        logic [3:0]  b;
        logic        pe;
        logic        es;
        pe = (v.u == 2'd1) || (v.u == 2'd2);
        fr = {2'b11, pe ? v.par : 1'b1, v.d, 1'b0};
        got = '0;
        sb_q.push_back(v.d);
        dv[v.u] = 1'b1;
        data[v.u] = v.d;
        for (int k = 1; k <= v.len + 2; k++) begin
            @(negedge clk);
            dv[v.u] = 1'b0;
            if (k == 1) data[v.u] = ~v.d;
            b = 4'((k - 1) / CPB);
            es = (k > v.len) ? 1'b1 : fr[b];
            check($sformatf("u%0d d%h cyc%0d", v.u, v.d, k), {5'd0, ser[v.u], busy[v.u], done[v.u]},
                  {5'd0, es, k <= v.len, k == v.len + 1});
            if (b >= 4'd1 && b <= 4'd8 && (k - 1) % CPB == 2) got = {ser[v.u], got[7:1]};
            if (k == v.g1 || k == v.g2) begin
                dv[v.u] = 1'b1;
                data[v.u] = 8'h3C;
            end
        end
        if (sb_q.size() == 0) check("scoreboard empty", got, 8'hxx);
        else check($sformatf("payload u%0d", v.u), got, sb_q.pop_front());
    endtask

    vec_t tbl [7] = '{
        '{2'd0, 8'hA5, 0,  0,  40, 1'b0},
        '{2'd1, 8'h07, 0,  0,  44, 1'b1},
        '{2'd2, 8'h07, 0,  0,  44, 1'b0},
        '{2'd3, 8'hFF, 0,  0,  44, 1'b0},
        '{2'd3, 8'h81, 0,  0,  44, 1'b0},
        '{2'd1, 8'h3A, 0,  0,  44, 1'b0},
        '{2'd0, 8'hA5, 14, 41, 40, 1'b0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset serial", {4'd0, ser}, 8'h0F);
        check("reset busy", {4'd0, busy}, 8'h00);
        check("reset done", {4'd0, done}, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) run_frame(tbl[i]);
        idle_check(2'd0, 12);
        dv[0] = 1'b1;
        data[0] = 8'hA5;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            dv[0] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("abort immediate", {5'd0, ser[0], busy[0], done[0]}, 8'b100);
        repeat (2) begin
            @(negedge clk);
            check("abort held", {5'd0, ser[0], busy[0], done[0]}, 8'b100);
        end
        rst_n = 1'b1;
        idle_check(2'd0, 5);
        run_frame('{2'd0, 8'h5A, 0, 0, 40, 1'b0});
        fifo = '{8'h11, 8'hC3, 8'h7E};
        while (fifo.size() > 0) run_frame('{2'd0, fifo.pop_front(), 0, 0, 40, 1'b0});
        idle_check(2'd0, 4);
        check("scoreboard drained", 8'(sb_q.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
